spi_loopback_engine: RTL and testbench

Parametrised stream processor between the RX and TX stream ports of spi_slave_fifo. It replaces the fixed single-register echo with a buffered transform path.
- Accepted RX words are transformed per a runtime mode, queued in an internal FIFO, and presented on the TX stream.
- A pattern-generator mode can source TX data independently of RX.
- It sits in the FPGA top level alongside the SPI slave and serves as the standard bring-up/loopback test block.

---
 rtl/spi_loopback_engine.sv | 148 ++++++++++++++
 tb/tb_spi_loopback_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_loopback_engine.sv
// Buffered RX->TX transform engine (echo / invert / add-offset / pattern) for spi_slave_fifo.
// Optional statistics counters are built when SPI_LOOPBACK_STATS_EN is defined.
module spi_loopback_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    mode,
    input  logic [DATA_WIDTH-1:0]         offset,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(BUF_DEPTH):0]    buf_count,
    output logic [CNT_WIDTH-1:0]          rx_words,
    output logic [CNT_WIDTH-1:0]          tx_words
);

    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        MODE_ECHO = 2'd0,
        MODE_INV  = 2'd1,
        MODE_ADD  = 2'd2,
        MODE_PAT  = 2'd3
    } mode_t;

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [DATA_WIDTH-1:0] r_pat;
    logic                  r_prev_pat;
    logic [DATA_WIDTH-1:0] r_tx_data;

    mode_t                 w_mode;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pat_mode;
    logic                  w_rx_fire;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_pat_val;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [AW-1:0]         w_rd_next;
    logic [AW:0]           w_cnt_next;
    logic [DATA_WIDTH-1:0] w_head_next;

    assign w_mode     = mode_t'(mode);
    assign w_full     = (r_count == (AW+1)'(BUF_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pat_mode = (w_mode == MODE_PAT);

    assign rx_ready   = rst_n && !flush && (w_pat_mode || !w_full);
    assign w_rx_fire  = rx_valid && rx_ready;
    assign w_pop      = !w_empty && tx_ready && !flush;
    assign w_push     = !flush && (w_pat_mode ? !w_full : w_rx_fire);
    // Counter restarts from zero in the first cycle of any mode-3 stint.
    assign w_pat_val  = r_prev_pat ? r_pat : '0;

    always_comb begin
        w_push_data = rx_data;
        unique case (w_mode)
            MODE_ECHO: w_push_data = rx_data;
            MODE_INV:  w_push_data = ~rx_data;
            MODE_ADD:  w_push_data = rx_data + offset;
            MODE_PAT:  w_push_data = w_pat_val;
        endcase
    end

    always_comb begin
        w_rd_next  = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
        w_cnt_next = r_count;
        if (w_push && !w_pop)
            w_cnt_next = r_count + 1'b1;
        else if (!w_push && w_pop)
            w_cnt_next = r_count - 1'b1;
    end

    // Head of the queue after this edge; bypass the word being written when it becomes the head.
    assign w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? w_push_data : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pat      <= '0;
            r_prev_pat <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_prev_pat <= w_pat_mode;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_pat    <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rd_ptr <= w_rd_next;
                r_count  <= w_cnt_next;
                if (w_pat_mode)
                    r_pat <= w_push ? w_pat_val + 1'b1 : w_pat_val;
                if (w_cnt_next != '0)
                    r_tx_data <= w_head_next;
            end
        end
    end

    assign tx_valid  = !w_empty;
    assign tx_data   = r_tx_data;
    assign buf_count = r_count;

`ifdef SPI_LOOPBACK_STATS_EN
    logic [CNT_WIDTH-1:0] r_rx_words;
    logic [CNT_WIDTH-1:0] r_tx_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_words <= '0;
            r_tx_words <= '0;
        end else begin
            if (w_rx_fire)
                r_rx_words <= r_rx_words + 1'b1;
            if (w_pop)
                r_tx_words <= r_tx_words + 1'b1;
        end
    end

    assign rx_words = r_rx_words;
    assign tx_words = r_tx_words;
`else
    assign rx_words = '0;
    assign tx_words = '0;
`endif

endmodule

// File: tb/tb_spi_loopback_engine.sv
// Scoreboard bench for spi_loopback_engine: expected words queued at acceptance, compared at delivery.
module tb_spi_loopback_engine;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 16;
`ifdef SPI_LOOPBACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [DW-1:0] offset;
    logic          flush;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [4:0]    buf_count;
    logic [CW-1:0] rx_words;
    logic [CW-1:0] tx_words;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] m_pat = '0;
    logic [1:0]    m_prev = 2'd0;
    logic [CW-1:0] m_rx = '0;
    logic [CW-1:0] m_tx = '0;

    spi_loopback_engine #(
        .DATA_WIDTH(DW),
        .BUF_DEPTH (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .offset   (offset),
        .flush    (flush),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .buf_count(buf_count),
        .rx_words (rx_words),
        .tx_words (tx_words)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] xform(input logic [1:0] m, input logic [DW-1:0] d,
                                            input logic [DW-1:0] off);
        case (m)
            2'd1:    return ~d;
            2'd2:    return d + off;
            default: return d;
        endcase
    endfunction

    // Reference model stepped once per cycle, between active edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_pat  = '0;
            m_prev = 2'd0;
            m_rx   = '0;
            m_tx   = '0;
        end else begin
            int n;
            logic exp_rdy;
            logic [DW-1:0] pv;
            n = q.size();
            check("buf_count", 32'(buf_count), 32'(n));
            check("tx_valid", 32'(tx_valid), 32'(n != 0));
            if (n != 0) check("tx_data", 32'(tx_data), 32'(q[0]));
            check("rx_words", 32'(rx_words), STATS ? 32'(m_rx) : 32'd0);
            check("tx_words", 32'(tx_words), STATS ? 32'(m_tx) : 32'd0);
            if (flush) begin
                check("rx_ready_flush", 32'(rx_ready), 32'd0);
                q.delete();
                m_pat = '0;
            end else begin
                exp_rdy = (mode == 2'd3) || (n < DEPTH);
                check("rx_ready", 32'(rx_ready), 32'(exp_rdy));
                if (rx_valid && exp_rdy) m_rx++;
                if (n != 0 && tx_ready) begin
                    got.push_back(tx_data);
                    void'(q.pop_front());
                    m_tx++;
                end
                if (mode == 2'd3) begin
                    pv = (m_prev != 2'd3) ? '0 : m_pat;
                    if (n < DEPTH) begin
                        q.push_back(pv);
                        pv = pv + 1'b1;
                    end
                    m_pat = pv;
                end else if (rx_valid && exp_rdy) begin
                    q.push_back(xform(mode, rx_data, offset));
                end
            end
            m_prev = mode;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] w);
        int t;
        logic acc;
        t = 0;
        rx_data  = w;
        rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 200) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    logic [DW-1:0] echo_w[3] = '{8'h00, 8'h5A, 8'hFF};

    initial begin
        int g0;
        logic [CW-1:0] tx_before;
        rst_n = 1'b0; mode = 2'd0; offset = '0; flush = 1'b0;
        rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_buf_count", 32'(buf_count), 32'd0);
        #10 rst_n = 1'b1;
        tick(2);

        // Echo with one-cycle latency
        tx_ready = 1'b1;
        g0 = got.size();
        foreach (echo_w[i]) begin
            send(echo_w[i]);
            check("echo_lat_valid", 32'(tx_valid), 32'd1);
            check("echo_lat_data", 32'(tx_data), 32'(echo_w[i]));
        end
        tick(2);
        for (int unsigned i = 0; i < 3; i++)
            check("echo_word", (g0 + int'(i) < got.size()) ? 32'(got[g0+i]) : 32'hDEAD, 32'(echo_w[i]));
        check("echo_rx_words", 32'(rx_words), STATS ? 32'd3 : 32'd0);
        check("echo_tx_words", 32'(tx_words), STATS ? 32'd3 : 32'd0);

        // Invert and offset
        g0 = got.size();
        mode = 2'd1; send(8'h0F);
        mode = 2'd2; offset = 8'h10; send(8'hF8);
        tick(2);
        check("invert", 32'(got[g0]), 32'h0F0);
        check("offset", 32'(got[g0+1]), 32'h08);

        // Mode switch with words queued
        tx_ready = 1'b0; g0 = got.size();
        mode = 2'd1; send(8'h33); send(8'hC0);
        mode = 2'd2; offset = 8'h05; send(8'h33);
        mode = 2'd0; tick(1);
        tx_ready = 1'b1; tick(4);
        check("sw_q0", 32'(got[g0]), 32'hCC);
        check("sw_q1", 32'(got[g0+1]), 32'h3F);
        check("sw_q2", 32'(got[g0+2]), 32'h38);

        // Backpressure: 20 words into a 16-deep buffer
        tx_ready = 1'b0; g0 = got.size();
        for (int unsigned i = 1; i <= 16; i++) send(DW'(i));
        rx_data = 8'd17; rx_valid = 1'b1;
        tick(3);
        check("full_count", 32'(buf_count), 32'd16);
        check("full_rx_ready", 32'(rx_ready), 32'd0);
        tx_ready = 1'b1;
        for (int unsigned i = 17; i <= 20; i++) send(DW'(i));
        tick(20);
        check("bp_total", 32'(got.size() - g0), 32'd20);
        for (int unsigned i = 0; i < 20; i += 5)
            check("bp_order", 32'(got[g0+i]), i + 1);

        // Pattern generator with concurrent RX traffic
        g0 = got.size();
        mode = 2'd3; rx_valid = 1'b1;
        for (int i = 0; i < 262; i++) begin
            rx_data = DW'($urandom);
            tick(1);
        end
        rx_valid = 1'b0; mode = 2'd0;
        tick(3);
        check("pat_len", 32'(got.size() >= g0 + 258), 32'd1);
        if (got.size() >= g0 + 258) begin
            check("pat_0", 32'(got[g0]), 32'h00);
            check("pat_1", 32'(got[g0+1]), 32'h01);
            check("pat_255", 32'(got[g0+255]), 32'hFF);
            check("pat_wrap", 32'(got[g0+256]), 32'h00);
        end
        g0 = got.size();
        mode = 2'd3; tick(5);
        mode = 2'd0; tick(3);
        check("pat_restart0", 32'(got[g0]), 32'h00);
        check("pat_restart1", 32'(got[g0+1]), 32'h01);

        // Flush with a simultaneous TX handshake
        tx_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) send(DW'(8'hA0 + i));
        tx_before = tx_words;
        flush = 1'b1; tx_ready = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_count", 32'(buf_count), 32'd0);
        check("flush_tx_valid", 32'(tx_valid), 32'd0);
        check("flush_tx_words", 32'(tx_words), 32'(tx_before));
        tick(2);

        // Asynchronous reset mid-stream
        tx_ready = 1'b0;
        send(8'h11); send(8'h22); send(8'h33);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_count", 32'(buf_count), 32'd0);
        check("arst_rx_words", 32'(rx_words), 32'd0);
        check("arst_tx_words", 32'(tx_words), 32'd0);
        check("arst_rx_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        tx_ready = 1'b1; g0 = got.size();
        send(8'h77);
        tick(2);
        check("post_rst", 32'(got[g0]), 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 32'd1, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
